// File: rtl/alu54_sched_pkg.sv
// Shared types and helpers for the ALU54 adder scheduler.
// Operands are 32-bit two's complement; sums carry one extra bit so they never overflow.
package alu54_sched_pkg;

    localparam int ALU_W      = 32;
    localparam int SUM_W      = 33;
    localparam int HARD_W     = 54;
    localparam int HARD_OUT_W = 55;

    typedef logic [ALU_W-1:0]        opnd_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    function automatic logic [HARD_W-1:0] sext_hard(input opnd_t v);
        return {{(HARD_W-ALU_W){v[ALU_W-1]}}, v};
    endfunction

    function automatic sum_t add_sext(input opnd_t a, input opnd_t b);
        return $signed({a[ALU_W-1], a}) + $signed({b[ALU_W-1], b});
    endfunction

endpackage

// File: rtl/Gowin_ALU54plus.sv
// Behavioural stand-in for the vendor ALU54 add wrapper: signed 54-bit add, registered output,
// clock enable and synchronous reset. The cascade output is not modelled and reads as zero.
module Gowin_ALU54plus (
    output logic [54:0] dout,
    output logic [54:0] caso,
    input  logic [53:0] a,
    input  logic [53:0] b,
    input  logic        ce,
    input  logic        clk,
    input  logic        reset
);

    logic [54:0] dout_q;
    logic [54:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (ce) begin
            dout_d = {a[53], a} + {b[53], b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
    assign caso = '0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index.
// The pointer only moves when the caller reports that the grant was actually taken.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = gnt_idx;
        end
    end

    // Resetting to N-1 makes requester 0 the first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu54_add_sched.sv
// Shares one registered 32-bit signed adder among NREQ requesters, one add per cycle,
// round-robin; the sum comes back one cycle after acceptance, tagged with the requester index.
module alu54_add_sched
    import alu54_sched_pkg::*;
#(
    parameter int  NREQ         = 4,
    parameter bit  USE_HARD_ALU = 1'b1,
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  opnd_t [NREQ-1:0]    req_a,
    input  opnd_t [NREQ-1:0]    req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output sum_t                rsp_sum,
    input  logic                rsp_ready,
    output logic [31:0]         op_cnt
);

    // Handshake: a request moves on req_valid[i] & req_ready[i]; a response moves on
    // rsp_valid & rsp_ready. A refused response freezes the whole pipe (adder, tag, pointer).
    logic            stall;
    logic            ce;
    logic            xfer;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    opnd_t           op_a;
    opnd_t           op_b;
    sum_t            sum_w;

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     op_cnt_q, op_cnt_d;

    assign stall = rsp_valid_q & ~rsp_ready;
    assign ce    = ~stall;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        req_ready   = (stall || reset) ? '0 : gnt;
        xfer        = |req_ready;
        op_a        = req_a[gnt_idx];
        op_b        = req_b[gnt_idx];
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        if (ce) begin
            rsp_valid_d = xfer;
            rsp_id_d    = gnt_idx;
        end
        op_cnt_d = op_cnt_q + 32'(xfer);
    end

    // Tag flops follow the adder output register: same enable, same synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            op_cnt_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    if (USE_HARD_ALU) begin : g_hard
        logic [HARD_OUT_W-1:0] alu_dout;
        logic [HARD_OUT_W-1:0] alu_caso;
        logic                  unused_alu;

        Gowin_ALU54plus u_alu (
            .dout  (alu_dout),
            .caso  (alu_caso),
            .a     (sext_hard(op_a)),
            .b     (sext_hard(op_b)),
            .ce    (ce),
            .clk   (clk),
            .reset (reset)
        );

        assign sum_w      = $signed(alu_dout[SUM_W-1:0]);
        assign unused_alu = ^{alu_dout[HARD_OUT_W-1:SUM_W], alu_caso};
    end else begin : g_soft
        sum_t sum_q;
        sum_t sum_d;

        always_comb begin
            sum_d = sum_q;
            if (ce) begin
                sum_d = add_sext(op_a, op_b);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sum_q <= '0;
            end else begin
                sum_q <= sum_d;
            end
        end

        assign sum_w = sum_q;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = sum_w;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu54_add_sched.sv
// Bench for alu54_add_sched: hard-ALU and behavioural-adder builds run side by side on the
// same stimulus and are both held against a queue-based reference of the sharing rules.
module tb_alu54_add_sched;

    localparam int NREQ = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0][31:0] req_a = '0;
    logic [NREQ-1:0][31:0] req_b = '0;
    logic                  rsp_ready = 1'b1;

    logic [NREQ-1:0] req_ready_h, req_ready_s;
    logic            rsp_valid_h, rsp_valid_s;
    logic [1:0]      rsp_id_h, rsp_id_s;
    logic [32:0]     rsp_sum_h, rsp_sum_s;
    logic [31:0]     op_cnt_h, op_cnt_s;

    alu54_add_sched #(.NREQ(NREQ), .USE_HARD_ALU(1'b1)) dut_h (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready_h), .rsp_valid(rsp_valid_h), .rsp_id(rsp_id_h),
        .rsp_sum(rsp_sum_h), .rsp_ready(rsp_ready), .op_cnt(op_cnt_h)
    );

    alu54_add_sched #(.NREQ(NREQ), .USE_HARD_ALU(1'b0)) dut_s (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_id(rsp_id_s),
        .rsp_sum(rsp_sum_s), .rsp_ready(rsp_ready), .op_cnt(op_cnt_s)
    );

    always #5 clk = ~clk;

    // Reference: one pending response at most, held in a queue of {id, sum}.
    logic [34:0] exp_q[$];
    bit          m_valid = 1'b0;
    logic [31:0] m_cnt = '0;
    int          m_last = NREQ - 1;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 33'(sa + sb);
    endfunction

    // One clock: check outputs at the falling edge, then advance the reference at the rising edge.
    task automatic step();
        int          win;
        bit          stall;
        logic [3:0]  exp_rdy;
        logic [34:0] front;
        @(negedge clk);
        stall   = m_valid && !rsp_ready;
        win     = (reset || stall) ? -1 : rr_pick(req_valid, m_last);
        exp_rdy = (win < 0) ? 4'b0 : 4'(1 << win);
        check("req_ready_hard", 64'(req_ready_h), 64'(exp_rdy));
        check("req_ready_soft", 64'(req_ready_s), 64'(exp_rdy));
        check("rsp_valid_hard", 64'(rsp_valid_h), 64'(m_valid));
        check("rsp_valid_soft", 64'(rsp_valid_s), 64'(m_valid));
        check("op_cnt_hard", 64'(op_cnt_h), 64'(m_cnt));
        check("op_cnt_soft", 64'(op_cnt_s), 64'(m_cnt));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_queue: got empty expected one entry at %0t", $time);
            end else begin
                front = exp_q[0];
                check("rsp_id_hard", 64'(rsp_id_h), 64'(front[34:33]));
                check("rsp_id_soft", 64'(rsp_id_s), 64'(front[34:33]));
                check("rsp_sum_hard", 64'(rsp_sum_h), 64'(front[32:0]));
                check("rsp_sum_soft", 64'(rsp_sum_s), 64'(front[32:0]));
            end
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_cnt   = '0;
            m_last  = NREQ - 1;
            exp_q.delete();
        end else begin
            if (m_valid && rsp_ready) void'(exp_q.pop_front());
            if (!stall) begin
                if (win >= 0) begin
                    exp_q.push_back({2'(win), ref_sum(req_a[win], req_b[win])});
                    m_cnt++;
                    m_last  = win;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        #1;
    endtask

    function automatic logic [31:0] pick_opnd();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        // Reset with every requester asking: nothing may be accepted.
        reset     = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = $urandom();
            req_b[i] = $urandom();
        end
        step();
        step();
        check("reset_sum_hard", 64'(rsp_sum_h), 64'd0);
        check("reset_sum_soft", 64'(rsp_sum_s), 64'd0);
        check("reset_id_hard", 64'(rsp_id_h), 64'd0);
        reset     = 1'b0;
        req_valid = '0;
        step();

        // Single request on requester 0.
        req_valid = 4'b0001;
        req_a[0]  = 32'd5;
        req_b[0]  = 32'd7;
        step();
        check("dir_5p7_sum", 64'(rsp_sum_h), 64'd12);
        check("dir_5p7_cnt", 64'(op_cnt_h), 64'd1);
        req_valid = '0;
        step();

        // Signed extremes.
        req_valid = 4'b0010;
        req_a[1]  = 32'hFFFF_FFFF;
        req_b[1]  = 32'hFFFF_FFFF;
        step();
        check("dir_m1m1_sum", 64'(rsp_sum_h), 64'h1_FFFF_FFFE);
        req_valid = 4'b0100;
        req_a[2]  = 32'h7FFF_FFFF;
        req_b[2]  = 32'h7FFF_FFFF;
        step();
        check("dir_maxmax_sum", 64'(rsp_sum_s), 64'h0_FFFF_FFFE);
        req_valid = '0;
        step();

        // All requesters busy at full throughput, then a three-cycle stall.
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 32'(i * 16);
            req_b[i] = 32'(i);
        end
        repeat (9) step();
        rsp_ready = 1'b0;
        repeat (3) step();
        rsp_ready = 1'b1;
        repeat (4) step();
        req_valid = '0;
        step();

        // Reset right after a transfer drops the in-flight sum.
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        reset     = 1'b1;
        step();
        check("dir_rst_valid", 64'(rsp_valid_h), 64'd0);
        check("dir_rst_cnt", 64'(op_cnt_h), 64'd0);
        reset     = 1'b0;
        req_valid = 4'b1000;
        req_a[3]  = 32'd100;
        req_b[3]  = 32'hFFFF_FF9C;
        step();
        check("dir_req3_id", 64'(rsp_id_h), 64'd3);
        check("dir_req3_sum", 64'(rsp_sum_s), 64'd0);
        req_valid = '0;
        step();

        // Counter wrap from all-ones.
        force dut_h.op_cnt_q = 32'hFFFF_FFFF;
        force dut_s.op_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut_h.op_cnt_q;
        release dut_s.op_cnt_q;
        m_cnt     = 32'hFFFF_FFFF;
        req_valid = 4'b0010;
        step();
        check("dir_wrap_cnt_hard", 64'(op_cnt_h), 64'd0);
        check("dir_wrap_cnt_soft", 64'(op_cnt_s), 64'd0);
        req_valid = '0;
        step();

        // Random traffic with back-pressure and occasional resets.
        repeat (400) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                req_a[i] = pick_opnd();
                req_b[i] = pick_opnd();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 60) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
